// File: rtl/fbr_pkg.sv
// fbr_pkg: shared opcodes, funct3/state enums and RV32I immediate decoders for the branch resolver
package fbr_pkg;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  typedef enum logic [2:0] {
    F3_EQ  = 3'b000,
    F3_NE  = 3'b001,
    F3_LT  = 3'b100,
    F3_GE  = 3'b101,
    F3_LTU = 3'b110,
    F3_GEU = 3'b111
  } funct3_e;
  typedef enum logic [1:0] {RUN, HOLD, SEEK} state_e;
  function automatic logic [31:0] imm_i(input logic [31:0] i);
    return {{20{i[31]}}, i[31:20]};
  endfunction
  function automatic logic [31:0] imm_b(input logic [31:0] i);
    return {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
  endfunction
  function automatic logic [31:0] imm_j(input logic [31:0] i);
    return {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
  endfunction
  function automatic logic is_ctl(input logic [31:0] i);
    return i[6:0] == OP_JAL || i[6:0] == OP_JALR ||
           (i[6:0] == OP_BRANCH && i[14:13] != 2'b01);
  endfunction
endpackage

// File: rtl/branch_cond_unit.sv
// branch_cond_unit: combinational branch condition and target computation for JAL/JALR/BRANCH
module branch_cond_unit
  import fbr_pkg::*;
(
  input  logic [31:0] instr,
  input  logic [31:0] pc,
  input  logic [31:0] rs1,
  input  logic [31:0] rs2,
  output logic        taken,
  output logic [31:0] target
);
  logic [6:0] op;
  logic [2:0] f3;
  logic eq, lt, ltu, cond;
  logic [31:0] dest;
  always_comb begin
    op = instr[6:0];
    f3 = instr[14:12];
    eq = rs1 == rs2;
    lt = $signed(rs1) < $signed(rs2);
    ltu = rs1 < rs2;
    cond = f3 == F3_EQ  ? eq :
           f3 == F3_NE  ? !eq :
           f3 == F3_LT  ? lt :
           f3 == F3_GE  ? !lt :
           f3 == F3_LTU ? ltu :
           f3 == F3_GEU ? !ltu : 1'b0;
    taken = op == OP_JAL || op == OP_JALR || (op == OP_BRANCH && cond);
    dest = op == OP_JAL  ? pc + imm_j(instr) :
           op == OP_JALR ? (rs1 + imm_i(instr)) & ~32'd1 :
                           pc + imm_b(instr);
    target = taken ? dest : pc + 32'd4;
  end
endmodule

// File: rtl/fetch_branch_resolver.sv
// fetch_branch_resolver: pops decoder instructions, resolves control transfers and flushes the wrong path
module fetch_branch_resolver
  import fbr_pkg::*;
#(
  parameter int FLUSH_CYCLES = 2,
  parameter int SEEK_LIMIT   = 16,
  parameter int CNT_W        = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             dec_valid,
  input  logic [31:0]      dec_instr,
  input  logic [31:0]      dec_pc,
  output logic             dec_read_en,
  output logic [4:0]       rf_raddr1,
  output logic [4:0]       rf_raddr2,
  input  logic [31:0]      rf_rdata1,
  input  logic [31:0]      rf_rdata2,
  output logic             branch_resolved,
  output logic             branch_taken,
  output logic [31:0]      branch_pc,
  output logic [31:0]      branch_target,
  output logic             ex_valid,
  output logic [31:0]      ex_pc,
  output logic [31:0]      ex_instr,
  output logic [CNT_W-1:0] retired_count,
  output logic             seek_timeout
);
  localparam int FW = FLUSH_CYCLES > 0 ? $clog2(FLUSH_CYCLES + 1) : 1;
  localparam int SW = $clog2(SEEK_LIMIT + 1);
  state_e state, state_n;
  logic [FW-1:0] cnt, cnt_n;
  logic [SW-1:0] disc, disc_n;
  logic [31:0] tgt, tgt_n;
  logic timeout_n;
  logic d_valid;
  logic [31:0] d_instr, d_pc;
  logic d_ctl, taken, fire, load;
  logic [31:0] target;
  branch_cond_unit u_bcu (
    .instr  (d_instr),
    .pc     (d_pc),
    .rs1    (rf_rdata1),
    .rs2    (rf_rdata2),
    .taken  (taken),
    .target (target)
  );
  always_comb begin
    rf_raddr1 = d_instr[19:15];
    rf_raddr2 = d_instr[24:20];
    d_ctl = d_valid && is_ctl(d_instr);
    dec_read_en = !reset && (state == SEEK || (state == RUN && !d_ctl));
    fire = dec_valid && dec_read_en;
    load = fire;
    state_n = state;
    cnt_n = cnt;
    disc_n = disc;
    tgt_n = tgt;
    timeout_n = seek_timeout;
    if (state == RUN && d_ctl && taken) begin
      state_n = HOLD;
      cnt_n = FW'(FLUSH_CYCLES);
      disc_n = '0;
      tgt_n = target;
    end else if (state == HOLD) begin
      cnt_n = cnt - FW'(1);
      state_n = cnt_n == '0 ? SEEK : HOLD;
    end else if (state == SEEK && fire) begin
      if (dec_pc == tgt) begin
        state_n = RUN;
      end else begin
        load = 1'b0;
        disc_n = disc + SW'(1);
        if (disc_n == SW'(SEEK_LIMIT)) begin
          timeout_n = 1'b1;
          state_n = RUN;
        end
      end
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= RUN;
      cnt <= '0;
      disc <= '0;
      tgt <= '0;
      seek_timeout <= 1'b0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      disc <= disc_n;
      tgt <= tgt_n;
      seek_timeout <= timeout_n;
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      d_valid <= 1'b0;
      d_instr <= '0;
      d_pc <= '0;
      ex_valid <= 1'b0;
      ex_pc <= '0;
      ex_instr <= '0;
      branch_resolved <= 1'b0;
      branch_taken <= 1'b0;
      branch_pc <= '0;
      branch_target <= '0;
      retired_count <= '0;
    end else begin
      d_valid <= load;
      if (load) begin
        d_instr <= dec_instr;
        d_pc <= dec_pc;
      end
      ex_valid <= d_valid;
      if (d_valid) begin
        ex_pc <= d_pc;
        ex_instr <= d_instr;
      end
      branch_resolved <= d_ctl;
      branch_taken <= d_ctl && taken;
      if (d_ctl) begin
        branch_pc <= d_pc;
        branch_target <= target;
      end
      retired_count <= retired_count + CNT_W'(d_valid);
    end
  end
endmodule

// File: tb/tb_fetch_branch_resolver.sv
// tb_fetch_branch_resolver: scoreboard bench for fetch_branch_resolver
module tb_fetch_branch_resolver;
  typedef struct packed {logic [31:0] pc; logic [31:0] instr;} ins_t;
  typedef struct packed {logic [31:0] pc; logic taken; logic [31:0] target;} br_t;
  localparam logic [31:0] ALU = 32'h00100093;
  logic clk = 1'b0;
  logic reset, dec_valid, dec_read_en;
  logic [31:0] dec_instr, dec_pc, rf_rdata1, rf_rdata2;
  logic [4:0] rf_raddr1, rf_raddr2;
  logic branch_resolved, branch_taken, ex_valid, seek_timeout;
  logic [31:0] branch_pc, branch_target, ex_pc, ex_instr, retired_count;
  logic [31:0] regs [32];
  ins_t src[$];
  ins_t exp_ex[$];
  br_t exp_br[$];
  ins_t got_ex;
  br_t got_br;
  int n_vec = 0;
  int n_err = 0;
  int n_ret = 0;
  fetch_branch_resolver dut (
    .clk(clk), .reset(reset), .dec_valid(dec_valid), .dec_instr(dec_instr), .dec_pc(dec_pc),
    .dec_read_en(dec_read_en), .rf_raddr1(rf_raddr1), .rf_raddr2(rf_raddr2),
    .rf_rdata1(rf_rdata1), .rf_rdata2(rf_rdata2), .branch_resolved(branch_resolved),
    .branch_taken(branch_taken), .branch_pc(branch_pc), .branch_target(branch_target),
    .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_instr(ex_instr),
    .retired_count(retired_count), .seek_timeout(seek_timeout)
  );
  assign rf_rdata1 = regs[rf_raddr1];
  assign rf_rdata2 = regs[rf_raddr2];
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  function automatic logic [31:0] enc_b(input logic [2:0] f3, input logic [4:0] rs1, input logic [4:0] rs2, input logic [31:0] imm);
    return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], 7'b1100011};
  endfunction
  function automatic logic [31:0] enc_j(input logic [4:0] rd, input logic [31:0] imm);
    return {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'b1101111};
  endfunction
  function automatic logic [31:0] enc_jalr(input logic [4:0] rd, input logic [4:0] rs1, input logic [31:0] imm);
    return {imm[11:0], rs1, 3'b000, rd, 7'b1100111};
  endfunction
  task automatic feed(input logic [31:0] pc, input logic [31:0] instr);
    src.push_back('{pc, instr});
  endtask
  task automatic want_ex(input logic [31:0] pc, input logic [31:0] instr);
    exp_ex.push_back('{pc, instr});
    n_ret++;
  endtask
  task automatic want_br(input logic [31:0] pc, input logic taken, input logic [31:0] target);
    exp_br.push_back('{pc, taken, target});
  endtask
  task automatic drain();
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (src.size() == 0 && exp_ex.size() == 0 && exp_br.size() == 0) break;
    end
    repeat (3) @(negedge clk);
    check("drain_left", src.size() + exp_ex.size() + exp_br.size(), 0);
    check("retired", retired_count, n_ret);
  endtask
  task automatic wait_res();
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (branch_resolved) break;
    end
    check("res_seen", branch_resolved, 1);
  endtask
  always begin
    @(posedge clk);
    if (dec_valid && dec_read_en && src.size() > 0) void'(src.pop_front());
    #1;
    dec_valid = src.size() > 0;
    if (src.size() > 0) begin
      dec_pc = src[0].pc;
      dec_instr = src[0].instr;
    end
  end
  always @(negedge clk) begin
    if (ex_valid) begin
      if (exp_ex.size() > 0) got_ex = exp_ex.pop_front();
      else got_ex = '{32'hDEADBEEF, 32'hDEADBEEF};
      check("ex_pc", ex_pc, got_ex.pc);
      check("ex_instr", ex_instr, got_ex.instr);
    end
    if (branch_resolved) begin
      if (exp_br.size() > 0) got_br = exp_br.pop_front();
      else got_br = '{32'hDEADBEEF, 1'b0, 32'hDEADBEEF};
      check("br_pc", branch_pc, got_br.pc);
      check("br_taken", branch_taken, got_br.taken);
      check("br_target", branch_target, got_br.target);
    end
  end
  initial begin
    reset = 1'b1;
    dec_valid = 1'b0;
    dec_pc = '0;
    dec_instr = '0;
    for (int i = 0; i < 32; i++) regs[i] = '0;
    for (int i = 0; i < 5; i++) begin
      feed(32'(i * 4), ALU);
      want_ex(32'(i * 4), ALU);
    end
    repeat (2) @(negedge clk);
    check("rst_read_en", dec_read_en, 0);
    check("rst_ex_valid", ex_valid, 0);
    check("rst_count", retired_count, 0);
    reset = 1'b0;
    @(negedge clk);
    check("read_en_rise", dec_read_en, 1);
    drain();
    regs[5] = 7;
    regs[6] = 7;
    feed(32'h100, enc_b(3'b000, 5'd5, 5'd6, 32'h20));
    feed(32'h104, ALU);
    feed(32'h108, ALU);
    feed(32'h120, ALU);
    want_ex(32'h100, enc_b(3'b000, 5'd5, 5'd6, 32'h20));
    want_br(32'h100, 1'b1, 32'h120);
    want_ex(32'h120, ALU);
    wait_res();
    check("hold_0", dec_read_en, 0);
    @(negedge clk);
    check("hold_1", dec_read_en, 0);
    @(negedge clk);
    check("seek_open", dec_read_en, 1);
    drain();
    regs[7] = 32'hFFFFFFFF;
    regs[8] = 1;
    feed(32'h200, enc_b(3'b100, 5'd7, 5'd8, 32'h40));
    feed(32'h240, ALU);
    want_ex(32'h200, enc_b(3'b100, 5'd7, 5'd8, 32'h40));
    want_br(32'h200, 1'b1, 32'h240);
    want_ex(32'h240, ALU);
    drain();
    feed(32'h200, enc_b(3'b110, 5'd7, 5'd8, 32'h40));
    feed(32'h204, ALU);
    want_ex(32'h200, enc_b(3'b110, 5'd7, 5'd8, 32'h40));
    want_br(32'h200, 1'b0, 32'h204);
    want_ex(32'h204, ALU);
    wait_res();
    check("no_stall", dec_read_en, 1);
    drain();
    regs[9] = 32'h1001;
    feed(32'h300, enc_jalr(5'd1, 5'd9, 32'd2));
    feed(32'h1002, ALU);
    want_ex(32'h300, enc_jalr(5'd1, 5'd9, 32'd2));
    want_br(32'h300, 1'b1, 32'h1002);
    want_ex(32'h1002, ALU);
    drain();
    feed(32'h400, enc_j(5'd1, 32'h100));
    feed(32'h404, ALU);
    feed(32'h500, ALU);
    want_ex(32'h400, enc_j(5'd1, 32'h100));
    want_br(32'h400, 1'b1, 32'h500);
    want_ex(32'h500, ALU);
    wait_res();
    check("bubble_q", src.size(), 2);
    drain();
    feed(32'hA00, enc_b(3'b010, 5'd5, 5'd6, 32'h20));
    feed(32'hA04, ALU);
    want_ex(32'hA00, enc_b(3'b010, 5'd5, 5'd6, 32'h20));
    want_ex(32'hA04, ALU);
    drain();
    feed(32'h600, enc_b(3'b000, 5'd5, 5'd6, 32'h20));
    for (int i = 0; i < 16; i++) feed(32'h700 + 32'(i * 4), ALU);
    feed(32'h800, ALU);
    want_ex(32'h600, enc_b(3'b000, 5'd5, 5'd6, 32'h20));
    want_br(32'h600, 1'b1, 32'h620);
    want_ex(32'h800, ALU);
    drain();
    check("seek_timeout", seek_timeout, 1);
    check("run_after_to", dec_read_en, 1);
    feed(32'h900, enc_b(3'b000, 5'd5, 5'd6, 32'h20));
    want_ex(32'h900, enc_b(3'b000, 5'd5, 5'd6, 32'h20));
    want_br(32'h900, 1'b1, 32'h920);
    wait_res();
    reset = 1'b1;
    n_ret = 0;
    @(negedge clk);
    check("mid_timeout", seek_timeout, 0);
    check("mid_read_en", dec_read_en, 0);
    check("mid_ex_valid", ex_valid, 0);
    check("mid_ex_pc", ex_pc, 0);
    check("mid_ex_instr", ex_instr, 0);
    check("mid_res", branch_resolved, 0);
    check("mid_taken", branch_taken, 0);
    check("mid_br_pc", branch_pc, 0);
    check("mid_br_tgt", branch_target, 0);
    check("mid_count", retired_count, 0);
    reset = 1'b0;
    @(negedge clk);
    check("post_read_en", dec_read_en, 1);
    drain();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
